// File: rtl/rgb_pack_writer_pkg.sv
// Shared types for the ISP RGB pack writer.
// Pixel/word layouts, write FSM states, channel saturation.
package isp_pkg;
  localparam int ADR_W = 32;

  typedef logic [63:0] mem_word_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix8_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } wr_state_t;

  function automatic logic [7:0] sat8(
    input logic [15:0] c,
    input int unsigned sh
  );
    logic [15:0] s;
    s = c >> sh;
    return (s > 16'd255) ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/rgb_pack_writer_if.sv
// Frame-memory write port: word address/data with
// a wr_en/wr_ready handshake.
interface rgb_pack_writer_if;
  import isp_pkg::*;

  logic [ADR_W-1:0] wr_adr;
  mem_word_t        wr_data;
  logic             wr_en;
  logic             wr_ready;

  modport master (
    output wr_adr, wr_data, wr_en,
    input  wr_ready
  );

  modport slave (
    input  wr_adr, wr_data, wr_en,
    output wr_ready
  );
endinterface

// File: rtl/rgb_pack_writer_fifo.sv
// First-word-fall-through word FIFO; rdata reads 0
// while empty so the write bus is quiet.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;

  assign empty = (r_wp == r_rp);
  assign full  = (r_wp[AW] != r_rp[AW]) &&
                 (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign rdata = empty ? '0 : r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (push)          r_wp <= r_wp + 1'b1;
      if (pop && !empty) r_rp <= r_rp + 1'b1;
    end
  end
endmodule

// File: rtl/rgb_pack_writer.sv
// Saturates 16-bit RGB to 8 bits, packs two pixels per
// 64-bit word and writes a frame to consecutive addresses.
module rgb_pack_writer
  import isp_pkg::*;
#(
  parameter int unsigned IN_SHIFT   = 4,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [15:0]      crop_width,
  input  logic [15:0]      crop_height,
  input  logic             cc_data_valid,
  input  logic [15:0]      red,
  input  logic [15:0]      green,
  input  logic [15:0]      blue,
  output logic             overflow,
  output logic             done,
  rgb_pack_writer_if.master wr
);
  wr_state_t r_state;
  wr_state_t w_next;

  logic [ADR_W-1:0] r_base;
  logic [31:0]      r_total;
  logic [31:0]      r_nwords;
  logic [31:0]      r_pix_cnt;
  logic [31:0]      r_wr_cnt;
  logic [31:0]      r_drops;
  mem_word_t        r_pack;
  logic             r_push;
  logic             r_overflow;

  logic [31:0] w_total;
  pix8_t       w_pix;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_fire;
  logic        w_drop;
  logic        w_accept;
  logic        w_start_ok;

  assign w_total = 32'(crop_width) * 32'(crop_height);
  assign w_pix   = {8'h00, sat8(red, IN_SHIFT),
                    sat8(green, IN_SHIFT),
                    sat8(blue, IN_SHIFT)};

  assign w_start_ok = start &&
                      (r_state == IDLE || r_state == DONE);
  assign w_accept   = (r_state == RUN) && cc_data_valid &&
                      (r_pix_cnt != r_total);
  assign w_pop      = wr.wr_en && wr.wr_ready;
  // A pop frees a slot in the same cycle, so a full FIFO
  // can still take the word if it is also being drained.
  assign w_fire     = r_push && (!w_full || w_pop);
  assign w_drop     = r_push && !w_fire;

  assign wr.wr_en  = !w_empty;
  assign wr.wr_adr = r_base + r_wr_cnt;
  assign overflow  = r_overflow;
  assign done      = (r_state == DONE);

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_fire),
    .pop   (w_pop),
    .wdata (r_pack),
    .rdata (wr.wr_data),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) w_next = (w_total == '0) ? DONE : RUN;
      end
      RUN: begin
        if (r_push && r_pix_cnt == r_total) w_next = FLUSH;
      end
      FLUSH: begin
        if (r_wr_cnt == r_nwords - r_drops) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base     <= '0;
      r_total    <= '0;
      r_nwords   <= '0;
      r_pix_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_drops    <= '0;
      r_pack     <= '0;
      r_push     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (w_start_ok) begin
        r_base     <= base_adr;
        r_total    <= w_total;
        r_nwords   <= 32'(({1'b0, w_total} + 33'd1) >> 1);
        r_pix_cnt  <= '0;
        r_wr_cnt   <= '0;
        r_drops    <= '0;
        r_pack     <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_pop) r_wr_cnt <= r_wr_cnt + 32'd1;
        if (w_drop) begin
          r_drops    <= r_drops + 32'd1;
          r_overflow <= 1'b1;
        end
        if (w_accept) begin
          r_pix_cnt <= r_pix_cnt + 32'd1;
          if (!r_pix_cnt[0]) begin
            r_pack <= {32'h0, w_pix};
            r_push <= (r_pix_cnt + 32'd1 == r_total);
          end else begin
            r_pack[63:32] <= w_pix;
            r_push        <= 1'b1;
          end
        end
      end
    end
  end
endmodule
